// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the decode hazard/forwarding controller.
// In-flight mirror entry layout and forward-select encoding.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_E   = 2'b01,
        FWD_M   = 2'b10,
        FWD_W   = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       w_enable;
        logic       fwd;
    } inflight_t;

    localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/hazard_src_resolve.sv
// Resolves one Decode source operand against the E/M/W mirror.
// Youngest matching writer wins; non-forwardable E/M matches stall.
module hazard_src_resolve
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic       uses,
    input  inflight_t  ent_e,
    input  inflight_t  ent_m,
    input  inflight_t  ent_w,
    output fwd_sel_e   fwd_sel,
    output logic       stall
);

    logic live;
    logic hit_e;
    logic hit_m;
    logic hit_w;
    logic pick_e;
    logic pick_m;
    logic pick_w;

    assign live  = uses && (src != ZERO_REG);
    assign hit_e = live && ent_e.valid && ent_e.w_enable
                   && (ent_e.rd == src);
    assign hit_m = live && ent_m.valid && ent_m.w_enable
                   && (ent_m.rd == src);
    assign hit_w = live && ent_w.valid && ent_w.w_enable
                   && (ent_w.rd == src);

    // Priority E > M > W flattened into one-hot picks.
    assign pick_e = hit_e;
    assign pick_m = hit_m && !hit_e;
    assign pick_w = hit_w && !hit_e && !hit_m;

    // Select forward source or request a stall for the chosen match.
    always_comb begin
        fwd_sel = FWD_REG;
        stall   = 1'b0;
        unique case (1'b1)
            pick_e: begin
                if (ent_e.fwd) fwd_sel = FWD_E;
                else           stall   = 1'b1;
            end
            pick_m: begin
                if (ent_m.fwd) fwd_sel = FWD_M;
                else           stall   = 1'b1;
            end
            pick_w:  fwd_sel = FWD_W;
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: stall, forward select, issue.
// Tracks E/M/W writers in a small mirror of the pipeline.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rstd,
    input  logic        D_valid,
    input  logic [4:0]  D_rs1_addr,
    input  logic [4:0]  D_rs2_addr,
    input  logic        D_uses_rs1,
    input  logic        D_uses_rs2,
    input  logic [4:0]  D_rd_addr,
    input  logic        D_w_enable,
    input  logic        D_is_arismetic_logic,
    input  logic        flush,
    output logic        stall,
    output logic [1:0]  DE_rs1_fwd_sel,
    output logic [1:0]  DE_rs2_fwd_sel,
    output logic        issue,
    output logic [31:0] stall_count
);

    inflight_t ent_e;
    inflight_t ent_m;
    inflight_t ent_w;
    fwd_sel_e  sel1;
    fwd_sel_e  sel2;
    logic      stall1;
    logic      stall2;
    logic      use1;
    logic      use2;

    // Registers at or above NUM_REGS do not exist and never match.
    assign use1 = D_uses_rs1 && (int'(D_rs1_addr) < NUM_REGS);
    assign use2 = D_uses_rs2 && (int'(D_rs2_addr) < NUM_REGS);

    hazard_src_resolve u_rs1 (
        .src     (D_rs1_addr),
        .uses    (use1),
        .ent_e   (ent_e),
        .ent_m   (ent_m),
        .ent_w   (ent_w),
        .fwd_sel (sel1),
        .stall   (stall1)
    );

    hazard_src_resolve u_rs2 (
        .src     (D_rs2_addr),
        .uses    (use2),
        .ent_e   (ent_e),
        .ent_m   (ent_m),
        .ent_w   (ent_w),
        .fwd_sel (sel2),
        .stall   (stall2)
    );

    // Reset gating keeps stall low as soon as rstd falls.
    assign stall = rstd && D_valid && !flush && (stall1 || stall2);
    assign issue = D_valid && !stall && !flush;
    assign DE_rs1_fwd_sel = sel1;
    assign DE_rs2_fwd_sel = sel2;

    // Advance the mirror; a flushed E instruction never reaches M.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            ent_e <= '0;
            ent_m <= '0;
            ent_w <= '0;
        end else begin
            ent_w <= ent_m;
            ent_m <= flush ? '0 : ent_e;
            if (issue) begin
                ent_e.valid    <= 1'b1;
                ent_e.rd       <= D_rd_addr;
                ent_e.w_enable <= D_w_enable;
                ent_e.fwd      <= D_is_arismetic_logic;
            end else begin
                ent_e <= '0;
            end
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            stall_count <= '0;
        end else if (stall && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl.
// Inputs change after negedge; outputs sampled 1ns later.
module tb_hazard_ctrl;

    logic        clk;
    logic        rstd;
    logic        D_valid;
    logic [4:0]  D_rs1_addr;
    logic [4:0]  D_rs2_addr;
    logic        D_uses_rs1;
    logic        D_uses_rs2;
    logic [4:0]  D_rd_addr;
    logic        D_w_enable;
    logic        D_is_arismetic_logic;
    logic        flush;
    logic        stall;
    logic [1:0]  DE_rs1_fwd_sel;
    logic [1:0]  DE_rs2_fwd_sel;
    logic        issue;
    logic [31:0] stall_count;

    int n_chk;
    int n_pass;

    hazard_ctrl #(.NUM_REGS(32)) dut (
        .clk                  (clk),
        .rstd                 (rstd),
        .D_valid              (D_valid),
        .D_rs1_addr           (D_rs1_addr),
        .D_rs2_addr           (D_rs2_addr),
        .D_uses_rs1           (D_uses_rs1),
        .D_uses_rs2           (D_uses_rs2),
        .D_rd_addr            (D_rd_addr),
        .D_w_enable           (D_w_enable),
        .D_is_arismetic_logic (D_is_arismetic_logic),
        .flush                (flush),
        .stall                (stall),
        .DE_rs1_fwd_sel       (DE_rs1_fwd_sel),
        .DE_rs2_fwd_sel       (DE_rs2_fwd_sel),
        .issue                (issue),
        .stall_count          (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Present a Decode instruction (or idle) for the coming cycle.
    task automatic drive(input logic v, input logic [4:0] r1,
                         input logic u1, input logic [4:0] r2,
                         input logic u2, input logic [4:0] rd,
                         input logic we, input logic alu,
                         input logic fl);
        @(negedge clk);
        D_valid = v;
        D_rs1_addr = r1;
        D_uses_rs1 = u1;
        D_rs2_addr = r2;
        D_uses_rs2 = u2;
        D_rd_addr = rd;
        D_w_enable = we;
        D_is_arismetic_logic = alu;
        flush = fl;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rstd = 1'b0;
        D_valid = 1'b1;
        D_rs1_addr = 5'd5;
        D_rs2_addr = 5'd5;
        D_uses_rs1 = 1'b1;
        D_uses_rs2 = 1'b1;
        D_rd_addr = 5'd5;
        D_w_enable = 1'b1;
        D_is_arismetic_logic = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_issue", issue, 1);
        chk("rst_sel1", DE_rs1_fwd_sel, 0);
        chk("rst_sel2", DE_rs2_fwd_sel, 0);
        chk("rst_cnt", stall_count, 0);
        @(negedge clk);
        rstd = 1'b1;
        idle(1);

        // add x5 ; add x6,x5 ; add x7,x5
        drive(1, 1, 1, 2, 1, 5, 1, 1, 0);
        chk("alu_first_stall", stall, 0);
        drive(1, 5, 1, 0, 0, 6, 1, 1, 0);
        chk("alu_e_stall", stall, 0);
        chk("alu_e_sel1", DE_rs1_fwd_sel, 2'b01);
        chk("alu_e_issue", issue, 1);
        drive(1, 5, 1, 0, 0, 7, 1, 1, 0);
        chk("alu_m_sel1", DE_rs1_fwd_sel, 2'b10);
        idle(3);

        // lw x5 ; add x6,x5,x5 -> two stall cycles then W
        drive(1, 1, 1, 0, 0, 5, 1, 0, 0);
        drive(1, 5, 1, 5, 1, 6, 1, 1, 0);
        chk("lu_stall1", stall, 1);
        chk("lu_issue1", issue, 0);
        drive(1, 5, 1, 5, 1, 6, 1, 1, 0);
        chk("lu_stall2", stall, 1);
        drive(1, 5, 1, 5, 1, 6, 1, 1, 0);
        chk("lu_stall3", stall, 0);
        chk("lu_issue3", issue, 1);
        chk("lu_sel1", DE_rs1_fwd_sel, 2'b11);
        chk("lu_sel2", DE_rs2_fwd_sel, 2'b11);
        chk("lu_cnt", stall_count, 2);
        idle(3);

        // lw x5 ; independent ; add x7,x5 -> one stall then W
        drive(1, 1, 1, 0, 0, 5, 1, 0, 0);
        drive(1, 2, 1, 0, 0, 8, 1, 1, 0);
        drive(1, 5, 1, 0, 0, 7, 1, 1, 0);
        chk("lu1_stall1", stall, 1);
        drive(1, 5, 1, 0, 0, 7, 1, 1, 0);
        chk("lu1_stall2", stall, 0);
        chk("lu1_sel1", DE_rs1_fwd_sel, 2'b11);
        idle(3);

        // lw x5 ; add x5 ; add x7,x5 -> ALU shadows load
        drive(1, 1, 1, 0, 0, 5, 1, 0, 0);
        drive(1, 1, 1, 0, 0, 5, 1, 1, 0);
        chk("shd_stall0", stall, 0);
        drive(1, 5, 1, 0, 0, 7, 1, 1, 0);
        chk("shd_stall", stall, 0);
        chk("shd_sel1", DE_rs1_fwd_sel, 2'b01);
        idle(3);

        // lw x5 ; flush ; later read of x5
        drive(1, 1, 1, 0, 0, 5, 1, 0, 0);
        drive(1, 5, 1, 0, 0, 6, 1, 1, 1);
        chk("fl_stall", stall, 0);
        chk("fl_issue", issue, 0);
        idle(2);
        drive(1, 5, 1, 0, 0, 6, 1, 1, 0);
        chk("fl_read_stall", stall, 0);
        chk("fl_read_sel1", DE_rs1_fwd_sel, 2'b00);
        idle(3);

        // add x9 ; add x0 ; read x0 and unused x9
        drive(1, 1, 1, 0, 0, 9, 1, 1, 0);
        drive(1, 1, 1, 0, 0, 0, 1, 1, 0);
        drive(1, 0, 1, 9, 0, 6, 1, 1, 0);
        chk("x0_sel1", DE_rs1_fwd_sel, 2'b00);
        chk("x0_stall", stall, 0);
        chk("unused_sel2", DE_rs2_fwd_sel, 2'b00);
        D_uses_rs2 = 1'b1;
        #1;
        chk("used_sel2", DE_rs2_fwd_sel, 2'b10);
        idle(3);

        // reset pulse during a load-use stall
        drive(1, 1, 1, 0, 0, 5, 1, 0, 0);
        drive(1, 5, 1, 0, 0, 6, 1, 1, 0);
        chk("rp_stall_pre", stall, 1);
        rstd = 1'b0;
        #1;
        chk("rp_stall_now", stall, 0);
        chk("rp_cnt", stall_count, 0);
        chk("rp_issue", issue, 1);
        @(negedge clk);
        rstd = 1'b1;
        #1;
        chk("rp_after_stall", stall, 0);
        chk("rp_after_sel1", DE_rs1_fwd_sel, 2'b00);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
